// File: rtl/spi_adc_scanner_if.sv
// spi_adc_scanner_if
//   SPI bus between the channel scanner (master) and an MCP320x-family ADC
//   (slave), SPI mode 0,0.
//   adc_sck   master -> slave   SPI clock, idles low
//   adc_cs_n  master -> slave   chip select, active low
//   adc_mosi  master -> slave   command bits (start, SGL, address, MSBF)
//   adc_miso  slave  -> master  null bit followed by the result, MSB first
interface spi_adc_scanner_if;
   logic adc_sck;
   logic adc_cs_n;
   logic adc_mosi;
   logic adc_miso;

   modport master (output adc_sck, output adc_cs_n, output adc_mosi, input adc_miso);
   modport slave  (input adc_sck, input adc_cs_n, input adc_mosi, output adc_miso);
endinterface

// File: rtl/spi_adc_scanner.sv
// spi_adc_scanner
//   Round-robin scanner for an MCP320x-family SPI ADC. Each enabled channel is
//   converted in turn; 2^AVG_LOG2 conversions per channel are averaged and the
//   result is published left-aligned in an OUT_BITS slice with a one-cycle
//   valid strobe.
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   enable        scan enable (a running frame always completes)
//   channel_mask  1 = channel takes part in the scan (sampled in IDLE only)
//   adc           SPI bus, master side (sck, cs_n, mosi, miso)
//   sample_data   per-channel result, channel n at [n*OUT_BITS +: OUT_BITS]
//   sample_valid  one-cycle strobe when the matching slice updates
//   busy          high while a conversion frame is in progress (CS low)
module spi_adc_scanner #(
   parameter int CHANNELS       = 2,
   parameter int ADDR_BITS      = 1,
   parameter int MSBF_BIT       = 1,
   parameter int SGL            = 1,
   parameter int DATA_BITS      = 12,
   parameter int OUT_BITS       = 16,
   parameter int SCK_DIV        = 8,
   parameter int CS_HIGH_CYCLES = 16,
   parameter int AVG_LOG2       = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [CHANNELS-1:0]          channel_mask,
   spi_adc_scanner_if.master            adc,
   output logic [CHANNELS*OUT_BITS-1:0] sample_data,
   output logic [CHANNELS-1:0]          sample_valid,
   output logic                         busy
);
   localparam int CMD_BITS   = 2 + ADDR_BITS + MSBF_BIT;
   localparam int TOTAL_BITS = CMD_BITS + 1 + DATA_BITS;
   localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int ACC_W      = DATA_BITS + AVG_LOG2;
   localparam int CNT_W      = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** AVG_LOG2);
   localparam logic [CH_W:0]    CH_COUNT = (CH_W + 1)'(CHANNELS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   logic [1:0]                  state_r;
   logic [15:0]                 div_cnt_r;
   logic [15:0]                 hold_cnt_r;
   logic [7:0]                  bit_cnt_r;
   logic [CH_W-1:0]             ptr_r;
   logic [CH_W-1:0]             cur_ch_r;
   logic [DATA_BITS-1:0]        shift_r;
   logic                        sck_r;
   logic                        cs_n_r;
   logic                        mosi_r;
   logic                        busy_r;
   logic [ACC_W-1:0]            acc_r [CHANNELS];
   logic [CNT_W-1:0]            cnt_r [CHANNELS];
   logic [CHANNELS*OUT_BITS-1:0] data_r;
   logic [CHANNELS-1:0]         valid_r;

   logic [2*CHANNELS-1:0]       rot_s;
   logic [CH_W:0]               off_s;
   logic [CH_W:0]               sum_s;
   logic                        next_found_s;
   logic [CH_W-1:0]             next_ch_s;
   logic [ACC_W-1:0]            acc_sum_s;
   logic [CNT_W-1:0]            cnt_inc_s;
   logic [OUT_BITS-1:0]         word_s;

   // Command bit sent in SCK period idx: start, SGL, address MSB-first,
   // optional MSBF, then zeros for the rest of the frame.
   function automatic logic cmd_bit(input logic [CH_W-1:0] ch, input logic [7:0] idx);
      logic [7:0] addr;
      int         k;
      logic       b;
      addr = 8'(ch);
      k    = int'(idx);
      if (k == 0) begin
         b = 1'b1;
      end else if (k == 1) begin
         b = (SGL != 0);
      end else if (k < 2 + ADDR_BITS) begin
         b = addr[3'(ADDR_BITS + 1 - k)];
      end else if ((k == 2 + ADDR_BITS) && (MSBF_BIT != 0)) begin
         b = 1'b1;
      end else begin
         b = 1'b0;
      end
      return b;
   endfunction

   // Next enabled channel at or after the pointer: rotate the mask so the
   // pointer sits at bit 0, then take the lowest set bit as the offset.
   always_comb begin
      rot_s        = {channel_mask, channel_mask} >> ptr_r;
      next_found_s = 1'b0;
      off_s        = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (rot_s[i]) begin
            next_found_s = 1'b1;
            off_s        = (CH_W + 1)'(i);
         end else begin
            next_found_s = next_found_s;
         end
      end
      sum_s = {1'b0, ptr_r} + off_s;
      if (sum_s >= CH_COUNT) begin
         next_ch_s = CH_W'(sum_s - CH_COUNT);
      end else begin
         next_ch_s = sum_s[CH_W-1:0];
      end
   end

   // Accumulate the finished conversion and form the left-aligned average.
   always_comb begin
      acc_sum_s = acc_r[cur_ch_r] + ACC_W'(shift_r);
      cnt_inc_s = cnt_r[cur_ch_r] + CNT_W'(1);
      word_s    = OUT_BITS'(acc_sum_s >> AVG_LOG2) << (OUT_BITS - DATA_BITS);
   end

   // Frame sequencer: SPI pin timing, result capture and averaging.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         div_cnt_r  <= 16'd0;
         hold_cnt_r <= 16'd0;
         bit_cnt_r  <= 8'd0;
         ptr_r      <= '0;
         cur_ch_r   <= '0;
         shift_r    <= '0;
         sck_r      <= 1'b0;
         cs_n_r     <= 1'b1;
         mosi_r     <= 1'b0;
         busy_r     <= 1'b0;
         data_r     <= '0;
         valid_r    <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            acc_r[c] <= '0;
            cnt_r[c] <= '0;
         end
      end else begin
         valid_r <= '0;
         case (state_r)
            ST_IDLE: begin
               // A channel dropped from the scan loses its partial average.
               for (int c = 0; c < CHANNELS; c++) begin
                  if (!channel_mask[c]) begin
                     acc_r[c] <= '0;
                     cnt_r[c] <= '0;
                  end
               end
               if (enable && next_found_s) begin
                  cur_ch_r  <= next_ch_s;
                  state_r   <= ST_SETUP;
                  cs_n_r    <= 1'b0;
                  busy_r    <= 1'b1;
                  mosi_r    <= cmd_bit(next_ch_s, 8'd0);
                  div_cnt_r <= 16'd0;
                  bit_cnt_r <= 8'd0;
                  shift_r   <= '0;
               end
            end
            ST_SETUP: begin
               // CS setup time; the first rising edge opens bit 0.
               if (div_cnt_r == 16'(SCK_DIV - 1)) begin
                  div_cnt_r <= 16'd0;
                  sck_r     <= 1'b1;
                  state_r   <= ST_SHIFT;
               end else begin
                  div_cnt_r <= div_cnt_r + 16'd1;
               end
            end
            ST_SHIFT: begin
               if (div_cnt_r == 16'(SCK_DIV - 1)) begin
                  div_cnt_r <= 16'd0;
                  if (sck_r) begin
                     sck_r <= 1'b0;
                     if (bit_cnt_r == 8'(TOTAL_BITS - 1)) begin
                        // CS rises together with the final falling edge.
                        state_r    <= ST_HOLD;
                        cs_n_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        mosi_r     <= 1'b0;
                        hold_cnt_r <= 16'd0;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 8'd1;
                        mosi_r    <= cmd_bit(cur_ch_r, bit_cnt_r + 8'd1);
                     end
                  end else begin
                     sck_r <= 1'b1;
                     // Periods after the command and null bit carry data.
                     if (bit_cnt_r > 8'(CMD_BITS)) begin
                        shift_r <= {shift_r[DATA_BITS-2:0], adc.adc_miso};
                     end
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + 16'd1;
               end
            end
            ST_HOLD: begin
               if (hold_cnt_r == 16'd0) begin
                  if (cnt_inc_s == CNT_FULL) begin
                     data_r[int'(cur_ch_r) * OUT_BITS +: OUT_BITS] <= word_s;
                     valid_r[cur_ch_r] <= 1'b1;
                     acc_r[cur_ch_r]   <= '0;
                     cnt_r[cur_ch_r]   <= '0;
                  end else begin
                     acc_r[cur_ch_r] <= acc_sum_s;
                     cnt_r[cur_ch_r] <= cnt_inc_s;
                  end
               end
               if (hold_cnt_r >= 16'(CS_HIGH_CYCLES - 1)) begin
                  state_r <= ST_IDLE;
                  ptr_r   <= (cur_ch_r == CH_W'(CHANNELS - 1)) ? '0 : cur_ch_r + CH_W'(1);
               end else begin
                  hold_cnt_r <= hold_cnt_r + 16'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               sck_r   <= 1'b0;
               cs_n_r  <= 1'b1;
               mosi_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign adc.adc_sck   = sck_r;
   assign adc.adc_cs_n  = cs_n_r;
   assign adc.adc_mosi  = mosi_r;
   assign sample_data   = data_r;
   assign sample_valid  = valid_r;
   assign busy          = busy_r;
endmodule

// File: tb/tb_spi_adc_scanner.sv
// tb_spi_adc_scanner
//   Directed bench for spi_adc_scanner. Three instances cover the default
//   MCP3202 setup (A), an 8-channel MCP3008-style command (B) and 4-way
//   averaging with a fast SCK (C). Each has a small ADC model that decodes
//   the command, drives the result on SCK falling edges and records frame
//   statistics (periods, command bits, SCK period, CS-high gap).
module tb_spi_adc_scanner;
   typedef struct packed {
      int         rise;
      int         fall;
      int         periods;
      int         frames;
      int         perr;
      int         gap;
      int         gap_min;
      int         sck_err;
      int         last_rise_cyc;
      int         end_cyc;
      logic [7:0] cmd;
      logic [7:0] cmd_last;
      logic       prev_sck;
      logic       prev_cs;
      logic       miso;
   } mstate_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        reset_a, reset_b, reset_c;
   logic        enable_a, enable_b, enable_c;
   logic [1:0]  mask_a, mask_c;
   logic [7:0]  mask_b;
   logic [31:0] data_a, data_c;
   logic [127:0] data_b;
   logic [1:0]  valid_a, valid_c;
   logic [7:0]  valid_b;
   logic        busy_a, busy_b, busy_c;

   spi_adc_scanner_if ia ();
   spi_adc_scanner_if ib ();
   spi_adc_scanner_if ic ();

   spi_adc_scanner dut_a (
      .clk(clk), .reset(reset_a), .enable(enable_a), .channel_mask(mask_a), .adc(ia),
      .sample_data(data_a), .sample_valid(valid_a), .busy(busy_a));

   spi_adc_scanner #(.CHANNELS(8), .ADDR_BITS(3), .MSBF_BIT(0), .DATA_BITS(10)) dut_b (
      .clk(clk), .reset(reset_b), .enable(enable_b), .channel_mask(mask_b), .adc(ib),
      .sample_data(data_b), .sample_valid(valid_b), .busy(busy_b));

   spi_adc_scanner #(.AVG_LOG2(2), .SCK_DIV(2), .CS_HIGH_CYCLES(4)) dut_c (
      .clk(clk), .reset(reset_c), .enable(enable_c), .channel_mask(mask_c), .adc(ic),
      .sample_data(data_c), .sample_valid(valid_c), .busy(busy_c));

   function automatic mstate_t init_state();
      mstate_t s;
      s = '0;
      s.gap_min       = 1000;
      s.last_rise_cyc = -1;
      s.end_cyc       = -100;
      s.prev_cs       = 1'b1;
      return s;
   endfunction

   // One negedge step of the ADC model and frame monitor.
   function automatic mstate_t model_step(input mstate_t s, input logic cs_n, input logic sck,
                                          input logic mosi, input int cmd_bits, input int data_bits,
                                          input int period, input logic [15:0] val, input int now);
      mstate_t n;
      int      j;
      n = s;
      n.prev_sck = sck;
      n.prev_cs  = cs_n;
      if (cs_n) begin
         if (sck) n.sck_err = s.sck_err + 1;
         if (!s.prev_cs) begin
            n.periods  = s.rise;
            n.cmd_last = s.cmd;
            n.frames   = s.frames + 1;
            n.end_cyc  = now;
            n.gap      = 1;
         end else begin
            n.gap = s.gap + 1;
         end
         n.rise = 0; n.fall = 0; n.miso = 1'b0; n.cmd = 8'h00; n.last_rise_cyc = -1;
      end else begin
         if (s.prev_cs && s.frames > 0 && s.gap < s.gap_min) n.gap_min = s.gap;
         if (sck && !s.prev_sck) begin
            if (s.rise < cmd_bits) n.cmd = {s.cmd[6:0], mosi};
            if (s.last_rise_cyc >= 0 && (now - s.last_rise_cyc) != period) n.perr = s.perr + 1;
            n.last_rise_cyc = now;
            n.rise = s.rise + 1;
         end
         if (!sck && s.prev_sck) begin
            n.fall = s.fall + 1;
            j = n.fall - cmd_bits - 1;
            if (j >= 0 && j < data_bits) n.miso = val[4'(data_bits - 1 - j)];
            else n.miso = 1'b0;
         end
      end
      return n;
   endfunction

   mstate_t     st_a, st_b, st_c;
   logic [15:0] val_a, val_b, val_c;

   assign val_a = st_a.cmd[1] ? 16'h0123 : 16'h0ABC;
   assign val_b = 16'h02A5;
   assign val_c = (st_c.frames == 0) ? 16'd100 : (st_c.frames == 1) ? 16'd101 :
                  (st_c.frames == 2) ? 16'd102 : (st_c.frames == 3) ? 16'd105 : 16'd0;
   assign ia.adc_miso = st_a.miso;
   assign ib.adc_miso = st_b.miso;
   assign ic.adc_miso = st_c.miso;

   always @(negedge clk) begin
      if (reset_a) st_a <= init_state();
      else st_a <= model_step(st_a, ia.adc_cs_n, ia.adc_sck, ia.adc_mosi, 4, 12, 16, val_a, cyc);
   end
   always @(negedge clk) begin
      if (reset_b) st_b <= init_state();
      else st_b <= model_step(st_b, ib.adc_cs_n, ib.adc_sck, ib.adc_mosi, 5, 10, 16, val_b, cyc);
   end
   always @(negedge clk) begin
      if (reset_c) st_c <= init_state();
      else st_c <= model_step(st_c, ic.adc_cs_n, ic.adc_sck, ic.adc_mosi, 4, 12, 4, val_c, cyc);
   end

   int onehot_err = 0, lat_err = 0, b_other = 0, b_pulses = 0, c_pulses0 = 0, c_pulses1 = 0;
   int c_pulse_frame = -1, a_low = 0, a_sck_hi = 0, a_busy_hi = 0;

   // Strobe and activity counters sampled away from the active edge.
   always @(negedge clk) begin
      if ($countones(valid_a) > 1 || $countones(valid_b) > 1 || $countones(valid_c) > 1)
         onehot_err <= onehot_err + 1;
      if (valid_a != 2'b00 && (cyc - st_a.end_cyc) != 1) lat_err <= lat_err + 1;
      if ((valid_b & 8'hDF) != 8'h00) b_other <= b_other + 1;
      if (valid_b[5]) b_pulses <= b_pulses + 1;
      if (valid_c[0]) begin
         c_pulses0     <= c_pulses0 + 1;
         c_pulse_frame <= st_c.frames;
      end
      if (valid_c[1]) c_pulses1 <= c_pulses1 + 1;
      if (!ia.adc_cs_n) a_low <= a_low + 1;
      if (ia.adc_sck) a_sck_hi <= a_sck_hi + 1;
      if (busy_a) a_busy_hi <= a_busy_hi + 1;
   end

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid_a(input int budget, output logic [1:0] v);
      v = 2'b00;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid_a != 2'b00) begin
            v = valid_a;
            break;
         end
      end
   endtask

   task automatic wait_valid_b(input int budget, output logic [7:0] v);
      v = 8'h00;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (valid_b != 8'h00) begin
            v = valid_b;
            break;
         end
      end
   endtask

   initial begin
      logic [1:0] va;
      logic [7:0] vb;
      bit         ok;
      int         s0, s1, s2;

      reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
      enable_a = 1'b0; enable_b = 1'b0; enable_c = 1'b0;
      mask_a = 2'b00; mask_b = 8'h00; mask_c = 2'b00;
      repeat (3) @(negedge clk);

      // Reset state of instance A.
      check("rst_cs_n", 32'(ia.adc_cs_n), 32'd1);
      check("rst_sck", 32'(ia.adc_sck), 32'd0);
      check("rst_mosi", 32'(ia.adc_mosi), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_data", data_a, 32'd0);
      check("rst_valid", 32'(valid_a), 32'd0);

      // Two-channel scan: alternating strobes, ch0 first.
      reset_a = 1'b0; enable_a = 1'b1; mask_a = 2'b11;
      wait_valid_a(2000, va);
      check("a1_valid", 32'(va), 32'd1);
      check("a1_slice0", 32'(data_a[15:0]), 32'h0000ABC0);
      check("a1_cmd", 32'(st_a.cmd_last[3:0]), 32'hD);
      check("a1_periods", 32'(st_a.periods), 32'd17);
      wait_valid_a(2000, va);
      check("a2_valid", 32'(va), 32'd2);
      check("a2_slice1", 32'(data_a[31:16]), 32'h00001230);
      check("a2_slice0_kept", 32'(data_a[15:0]), 32'h0000ABC0);
      check("a2_cmd", 32'(st_a.cmd_last[3:0]), 32'hF);
      check("a2_periods", 32'(st_a.periods), 32'd17);
      wait_valid_a(2000, va);
      check("a3_valid", 32'(va), 32'd1);
      check("a_sck_period", 32'(st_a.perr), 32'd0);
      check("a_gap_ge16", 32'(st_a.gap_min >= 16), 32'd1);
      check("a_sck_low_cs_high", 32'(st_a.sck_err), 32'd0);

      // Reset in bit 7 of the ch1 frame.
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!ia.adc_cs_n && st_a.rise == 8) begin
            ok = 1'b1;
            break;
         end
      end
      check("a_reach_bit7", 32'(ok), 32'd1);
      reset_a = 1'b1;
      @(negedge clk);
      check("mid_rst_cs_n", 32'(ia.adc_cs_n), 32'd1);
      check("mid_rst_sck", 32'(ia.adc_sck), 32'd0);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      check("mid_rst_data", data_a, 32'd0);
      check("mid_rst_valid", 32'(valid_a), 32'd0);
      reset_a = 1'b0;
      wait_valid_a(2000, va);
      check("post_rst_valid", 32'(va), 32'd1);
      check("post_rst_cmd", 32'(st_a.cmd_last[3:0]), 32'hD);
      check("post_rst_periods", 32'(st_a.periods), 32'd17);
      check("post_rst_data", data_a, 32'h0000ABC0);

      // Drop enable during bit 3: the frame completes, then the bus stays idle.
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!ia.adc_cs_n && st_a.rise == 4) begin
            ok = 1'b1;
            break;
         end
      end
      check("a_reach_bit3", 32'(ok), 32'd1);
      enable_a = 1'b0;
      wait_valid_a(2000, va);
      check("en_drop_valid", 32'(va), 32'd2);
      check("en_drop_slice1", 32'(data_a[31:16]), 32'h00001230);
      s0 = a_low;
      repeat (1000) @(negedge clk);
      check("en_drop_cs_idle", 32'(a_low - s0), 32'd0);

      // Enabled with an empty mask: nothing moves.
      mask_a = 2'b00; enable_a = 1'b1;
      s0 = a_sck_hi; s1 = a_busy_hi; s2 = a_low;
      repeat (10000) @(negedge clk);
      check("mask0_sck", 32'(a_sck_hi - s0), 32'd0);
      check("mask0_busy", 32'(a_busy_hi - s1), 32'd0);
      check("mask0_cs", 32'(a_low - s2), 32'd0);
      check("a_valid_latency", 32'(lat_err), 32'd0);

      // 8-channel, 3 address bits, no MSBF: only ch5 scanned.
      reset_b = 1'b0; enable_b = 1'b1; mask_b = 8'h20;
      for (int f = 0; f < 3; f++) begin
         wait_valid_b(2000, vb);
         check("b_valid", 32'(vb), 32'h20);
         check("b_slice5", 32'(data_b[95:80]), 32'h0000A940);
         check("b_cmd", 32'(st_b.cmd_last[4:0]), 32'h1D);
         check("b_periods", 32'(st_b.periods), 32'd16);
      end
      check("b_other_valid", 32'(b_other), 32'd0);
      check("b_gap_ge16", 32'(st_b.gap_min >= 16), 32'd1);
      enable_b = 1'b0;

      // Four-way averaging of 100, 101, 102, 105 on ch0.
      reset_c = 1'b0; enable_c = 1'b1; mask_c = 2'b01;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (st_c.frames == 4) begin
            ok = 1'b1;
            break;
         end
      end
      check("c_four_frames", 32'(ok), 32'd1);
      repeat (3) @(negedge clk);
      enable_c = 1'b0;
      check("c_pulses0", 32'(c_pulses0), 32'd1);
      check("c_pulse_frame", 32'(c_pulse_frame), 32'd4);
      check("c_pulses1", 32'(c_pulses1), 32'd0);
      check("c_slice0", 32'(data_c[15:0]), 32'h00000660);
      check("c_sck_period", 32'(st_c.perr), 32'd0);
      check("c_gap_ge4", 32'(st_c.gap_min >= 4), 32'd1);
      check("valid_onehot", 32'(onehot_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/spi_adc_scanner.md
Name: spi_adc_scanner

Overview:
- Parametrised successor to the single-channel MCP3202 sampler on the audio input path.
- Round-robin scans up to CHANNELS inputs of an MCP320x-family SPI ADC (mode 0,0) and optionally averages 2^AVG_LOG2 conversions per channel.
- Outputs each channel as a left-aligned OUT_BITS word with a per-channel one-cycle valid strobe.
- Feeds the audio LPF and mixer stage in the pixel/audio clock domain.

Parameters:
CHANNELS, 2, number of scanned channels (1..8)
ADDR_BITS, 1, channel address bits in the command word (1 = MCP3202, 3 = MCP3208)
MSBF_BIT, 1, 1 = append MSBF=1 bit after the address (MCP3202 style), 0 = omit it
SGL, 1, single-ended (1) or differential (0) bit sent in every command
DATA_BITS, 12, ADC result width
OUT_BITS, 16, output sample width; must be >= DATA_BITS
SCK_DIV, 8, clk cycles per SCK half-period (>= 2)
CS_HIGH_CYCLES, 16, minimum clk cycles CS is held high between conversions
AVG_LOG2, 0, log2 of conversions averaged per channel (0..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable
channel_mask  in  CHANNELS  1 = channel included in the scan
adc_sck  out  1  SPI clock, idles low
adc_cs_n  out  1  ADC chip select, active low
adc_mosi  out  1  command data to ADC
adc_miso  in  1  result data from ADC
sample_data  out  CHANNELS*OUT_BITS  per-channel result; channel n occupies bits [n*OUT_BITS +: OUT_BITS]
sample_valid  out  CHANNELS  one-cycle pulse when the corresponding sample_data slice updates
busy  out  1  high while a conversion frame is in progress (CS low)

Behaviour:
- Reset: adc_cs_n=1, adc_sck=0, adc_mosi=0, busy=0, sample_data=0, sample_valid=0, all accumulators and counts=0, channel pointer=0, state IDLE. Takes effect on the same edge, including mid-frame; no partial frame is completed.
- Frame bit count: CMD_BITS = 2 + ADDR_BITS + MSBF_BIT. Command = 1 (start), SGL, addr MSB-first, then 1 if MSBF_BIT. Followed by 1 null bit and DATA_BITS result bits. Total SCK periods = CMD_BITS + 1 + DATA_BITS (17 for the defaults).
- FSM:
  - IDLE: if enable && |channel_mask, select the next enabled channel at or after the pointer (wrapping) -> SETUP.
  - SETUP: cs_n=0, mosi=start bit; hold SCK_DIV cycles -> SHIFT.
  - SHIFT: SCK toggles every SCK_DIV cycles. mosi updates on SCK falling edges; miso is sampled on the rising edge of each data bit period; after the last rising edge and the following falling edge -> HOLD.
  - HOLD: cs_n=1, sck=0; count CS_HIGH_CYCLES, update the result, advance the pointer past the current channel -> IDLE.
- mosi is 0 after the command bits.
- Result update: acc[ch] += data, count[ch]++. When count reaches 2^AVG_LOG2: sample_data slice = (acc >> AVG_LOG2) left-aligned, i.e. {value, (OUT_BITS-DATA_BITS) zeros}; sample_valid[ch] pulses 1 cycle; acc and count clear. With AVG_LOG2=0, every conversion produces a sample. The accumulator is DATA_BITS+AVG_LOG2 wide and cannot overflow.
- Update timing: sample_valid asserts exactly 1 cycle after the final SCK falling edge (first HOLD cycle).
- enable deassertion mid-frame: the current frame and HOLD complete, then FSM stays IDLE. Accumulators are retained.
- channel_mask is sampled only in IDLE. Clearing a channel's mask bit clears its acc/count at the next IDLE. Mask all zero while enabled: stays IDLE, busy=0.
- Single enabled channel: it is converted back-to-back, with the CS_HIGH_CYCLES gap between frames.
- Only one bit of sample_valid is ever high in a given cycle.

Test Plan:
- Defaults, mask=2'b11, ADC model returns ch0=12'hABC, ch1=12'h123 -> alternating pulses: sample_valid[0] with slice0=16'hABC0, then sample_valid[1] with slice1=16'h1230. Each frame has 17 SCK periods of 16 clk, and mosi for ch1 = 1,1,1,1.
- Command check with CHANNELS=8, ADDR_BITS=3, MSBF_BIT=0, mask=8'h20 -> every frame has mosi=1,1,1,0,1 (ch5) and 16 SCK periods; only sample_valid[5] ever pulses.
- AVG_LOG2=2, mask=2'b01, ADC returns 100,101,102,105 -> exactly one sample_valid[0], after the 4th frame, with slice0=(408>>2)=102<<4=16'h0660.
- Reset asserted mid-SHIFT (bit 7) -> next cycle cs_n=1, sck=0, busy=0, all outputs 0. Next frame starts on channel 0 with a full command.
- enable dropped during bit 3 of a frame -> the frame finishes, sample_valid pulses once, then cs_n stays 1 indefinitely. mask=0 with enable=1 -> no SCK activity for 10000 cycles.
- Consecutive frames -> cs_n high gap >= CS_HIGH_CYCLES (16) clk, and sck stays low whenever cs_n=1.
